// File: rtl/gpu_pkg.sv
// Shared types and default sizing for the kernel block scheduler.
package gpu_pkg;

  localparam int NUM_CORES         = 4;
  localparam int THREADS_PER_BLOCK = 4;
  localparam int THREAD_CNT_W      = 8;
  localparam int BLOCK_ID_W        = 8;
  localparam int TPB_LOG2          = $clog2(THREADS_PER_BLOCK);
  localparam int TCNT_BLK_W        = TPB_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_free_picker.sv
// Combinational round-robin selector: first free core at or above the pointer, wrapping.
module rr_free_picker #(
  parameter int  N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_free,
  input  logic [PW-1:0] i_rr,
  output logic [N-1:0]  o_grant,
  output logic          o_valid
);

  logic [PW-1:0] w_idx;
  logic          w_hit;

  // Scan N positions starting at the pointer; the first free one wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_idx          = PW'((int'(i_rr) + k) % N);
      w_hit          = !o_valid && i_free[w_idx];
      o_grant[w_idx] = o_grant[w_idx] | w_hit;
      o_valid        = o_valid | w_hit;
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Kernel launch controller: splits a thread count into blocks, issues them
// round-robin to free cores and reports completion once all blocks retire.
module block_scheduler #(
  parameter int  NUM_CORES         = gpu_pkg::NUM_CORES,
  parameter int  THREADS_PER_BLOCK = gpu_pkg::THREADS_PER_BLOCK,
  parameter int  THREAD_CNT_W      = gpu_pkg::THREAD_CNT_W,
  parameter int  BLOCK_ID_W        = gpu_pkg::BLOCK_ID_W,
  localparam int TB_W              = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [THREAD_CNT_W-1:0]          thread_count,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [NUM_CORES-1:0]             core_start,
  output logic [NUM_CORES*BLOCK_ID_W-1:0]  core_block_id,
  output logic [NUM_CORES*TB_W-1:0]        core_thread_count,
  input  logic [NUM_CORES-1:0]             core_done
);

  import gpu_pkg::*;

  localparam int TPB_L2 = $clog2(THREADS_PER_BLOCK);
  localparam int CNT_W  = BLOCK_ID_W + 1;
  localparam int SUM_W  = THREAD_CNT_W + 1;
  localparam int PROD_W = CNT_W + THREAD_CNT_W;
  localparam int RR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  sched_state_t                          r_state;
  sched_state_t                          w_state_nxt;
  logic [THREAD_CNT_W-1:0]               r_tcount;
  logic [CNT_W-1:0]                      r_total;
  logic [CNT_W-1:0]                      r_next_block;
  logic [CNT_W-1:0]                      r_retired;
  logic [NUM_CORES-1:0]                  r_core_busy;
  logic [NUM_CORES-1:0]                  r_core_start;
  logic [NUM_CORES-1:0][BLOCK_ID_W-1:0]  r_blk_id;
  logic [NUM_CORES-1:0][TB_W-1:0]        r_blk_thr;
  logic [RR_W-1:0]                       r_rr;
  logic                                  r_done;
  logic                                  r_error;

  logic [SUM_W-1:0]     w_sum;
  logic [CNT_W-1:0]     w_total_calc;
  logic [NUM_CORES-1:0] w_free;
  logic [NUM_CORES-1:0] w_grant;
  logic                 w_pick_valid;
  logic [NUM_CORES-1:0] w_valid_done;
  logic [CNT_W-1:0]     w_inc;
  logic [RR_W-1:0]      w_grant_idx;
  logic [RR_W-1:0]      w_rr_nxt;
  logic                 w_issue;
  logic                 w_last_blk;
  logic                 w_launch;
  logic [PROD_W-1:0]    w_base;
  logic [TB_W-1:0]      w_last_thr;

  // Widened by one bit so a full-scale thread count cannot wrap the block count.
  assign w_sum        = {1'b0, thread_count} + SUM_W'(THREADS_PER_BLOCK - 1);
  assign w_total_calc = CNT_W'(w_sum >> TPB_L2);
  assign w_launch     = (r_state == IDLE) && start;

  // A core retiring this cycle may be granted now; its start pulse lands next cycle.
  assign w_free       = ~r_core_busy | core_done;
  assign w_valid_done = core_done & r_core_busy;

  rr_free_picker #(.N(NUM_CORES)) u_picker (
    .i_free  (w_free),
    .i_rr    (r_rr),
    .o_grant (w_grant),
    .o_valid (w_pick_valid)
  );

  assign w_issue    = (r_state == DISPATCH) && (r_next_block < r_total) && w_pick_valid;
  assign w_last_blk = (r_next_block == (r_total - CNT_W'(1)));
  assign w_base     = PROD_W'(r_total - CNT_W'(1)) << TPB_L2;
  assign w_last_thr = TB_W'(PROD_W'(r_tcount) - w_base);

  // Retire popcount and grant index for the round-robin pointer update.
  always_comb begin
    w_inc       = '0;
    w_grant_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_inc       = w_inc + CNT_W'(w_valid_done[i]);
      w_grant_idx = w_grant_idx | (w_grant[i] ? RR_W'(i) : RR_W'(0));
    end
    if (w_grant_idx == RR_W'(NUM_CORES - 1)) begin
      w_rr_nxt = '0;
    end else begin
      w_rr_nxt = w_grant_idx + RR_W'(1);
    end
  end

  // Next-state decode for the launch / dispatch / drain sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (thread_count == '0) ? DONE : DISPATCH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DISPATCH: begin
        if ((w_issue && w_last_blk) || (r_next_block >= r_total)) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = DISPATCH;
        end
      end
      DRAIN: begin
        if ((r_retired + w_inc) >= r_total) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Launch parameters, counters, per-core bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcount     <= '0;
      r_total      <= '0;
      r_next_block <= '0;
      r_retired    <= '0;
      r_core_busy  <= '0;
      r_core_start <= '0;
      r_blk_id     <= '0;
      r_blk_thr    <= '0;
      r_rr         <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_core_start <= w_issue ? w_grant : '0;
      r_core_busy  <= (r_core_busy & ~core_done) | (w_issue ? w_grant : '0);
      r_done       <= (r_state == DONE);
      r_error      <= r_error | (|(core_done & ~r_core_busy));
      if (w_launch) begin
        r_tcount     <= thread_count;
        r_total      <= w_total_calc;
        r_next_block <= '0;
        r_retired    <= '0;
      end else begin
        r_retired <= r_retired + w_inc;
        if (w_issue) begin
          r_next_block <= r_next_block + CNT_W'(1);
          r_rr         <= w_rr_nxt;
        end
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_issue && w_grant[i]) begin
          r_blk_id[i]  <= BLOCK_ID_W'(r_next_block);
          r_blk_thr[i] <= w_last_blk ? w_last_thr : TB_W'(THREADS_PER_BLOCK);
        end
      end
    end
  end

  assign busy              = (r_state != IDLE);
  assign done              = r_done;
  assign error             = r_error;
  assign core_start        = r_core_start;
  assign core_block_id     = r_blk_id;
  assign core_thread_count = r_blk_thr;

endmodule

// File: tb/tb_block_scheduler.sv
// Directed scoreboard bench for block_scheduler with a simple core responder model.
module tb_block_scheduler;

  localparam int NC = gpu_pkg::NUM_CORES;
  localparam int BW = gpu_pkg::BLOCK_ID_W;
  localparam int CW = gpu_pkg::TCNT_BLK_W;
  localparam int L2 = gpu_pkg::TPB_LOG2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        thread_count = 8'd0;
  logic              busy;
  logic              done;
  logic              error;
  logic [NC-1:0]     core_start;
  logic [NC*BW-1:0]  core_block_id;
  logic [NC*CW-1:0]  core_thread_count;
  logic [NC-1:0]     core_done = '0;

  typedef struct {
    int cyc;
    int core;
    int id;
    int thr;
  } start_t;

  start_t        q_start[$];
  int            q_done[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            hold[NC];
  logic [NC-1:0] man_mask = '0;
  int            man_seq = 0;

  block_scheduler dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .thread_count      (thread_count),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .core_start        (core_start),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
    .core_done         (core_done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Core model: each core raises core_done hold[i] cycles after its start pulse.
  initial begin
    int cnt[NC];
    int man_ack;
    man_ack = 0;
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      core_done = '0;
      if (!reset_n) begin
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        man_ack = man_seq;
      end else begin
        for (int i = 0; i < NC; i++) begin
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) core_done[i] = 1'b1;
          end
          if (core_start[i]) cnt[i] = hold[i];
        end
        if (man_seq != man_ack) begin
          core_done = core_done | man_mask;
          man_ack = man_seq;
        end
      end
    end
  end

  // Monitor: pops the expected queues whenever the DUT presents a start or done.
  initial begin
    start_t e;
    int     exp_cyc;
    forever begin
      @(negedge clk);
      if (core_start != '0) begin
        check("start_busy", busy, 1);
        if (q_start.size() == 0) begin
          check("start_unexpected", core_start, 0);
        end else begin
          e = q_start.pop_front();
          check("start_cycle", cyc, e.cyc);
          check("start_core", core_start, 1 << e.core);
          check("start_blk_id", core_block_id[e.core*BW +: BW], e.id);
          check("start_thr", core_thread_count[e.core*CW +: CW], e.thr);
        end
      end
      if (done) begin
        check("done_busy", busy, 0);
        if (q_done.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          exp_cyc = q_done.pop_front();
          check("done_cycle", cyc, exp_cyc);
        end
      end
    end
  end

  function automatic start_t mk(input int c, input int core, input int id, input int thr);
    start_t s;
    s.cyc = c; s.core = core; s.id = id; s.thr = thr;
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_core_start", core_start, 0);
    check("rst_blk_id", core_block_id, 0);
    check("rst_thr", core_thread_count, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic launch(input int n, output int c0);
    @(negedge clk);
    start = 1'b1;
    thread_count = 8'(n);
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    thread_count = 8'd0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q_start.size() != 0 || q_done.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", q_start.size() + q_done.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic inject(input logic [NC-1:0] m);
    @(posedge clk);
    #1;
    man_mask = m;
    man_seq++;
  endtask

  initial begin
    int c;
    hold = '{1, 1, 1, 1};

    // 10 threads: three blocks 4/4/2 to cores 0,1,2 back to back.
    do_reset();
    launch(10, c);
    check("t1_busy", busy, 1);
    q_start.push_back(mk(c + 2, 0, 0, 4));
    q_start.push_back(mk(c + 3, 1, 1, 4));
    q_start.push_back(mk(c + 4, 2, 2, 2));
    q_done.push_back(c + 7);
    wait_drain(40);
    check("t1_error", error, 0);

    // Zero threads: no issue, done two cycles after start, busy for one cycle.
    launch(0, c);
    check("t2_busy_hi", busy, 1);
    q_done.push_back(c + 2);
    @(negedge clk);
    check("t2_busy_lo", busy, 0);
    wait_drain(20);

    // 24 threads, cores hold 5 cycles: blocks 4,5 follow the first retirements.
    do_reset();
    hold = '{5, 5, 5, 5};
    launch(24, c);
    for (int k = 0; k < 4; k++) q_start.push_back(mk(c + 2 + k, k, k, 4));
    q_start.push_back(mk(c + 8, 0, 4, 4));
    q_start.push_back(mk(c + 9, 1, 5, 4));
    q_done.push_back(c + 16);
    wait_drain(60);

    // 22 threads: cores 0 and 2 retire together; pointer continues from core 1.
    do_reset();
    hold = '{6, 8, 4, 8};
    launch(22, c);
    for (int k = 0; k < 4; k++) q_start.push_back(mk(c + 2 + k, k, k, 4));
    q_start.push_back(mk(c + 9, 0, 4, 4));
    q_start.push_back(mk(c + 10, 2, 5, 2));
    q_done.push_back(c + 17);
    wait_drain(60);

    // Spurious retire on idle core 3 sets a sticky error; next launch still completes.
    hold = '{1, 1, 1, 1};
    inject(4'b1000);
    @(negedge clk);
    check("t5_err_before", error, 0);
    @(negedge clk);
    check("t5_err_set", error, 1);
    launch(5, c);
    q_start.push_back(mk(c + 2, 3, 0, 4));
    q_start.push_back(mk(c + 3, 0, 1, 1));
    q_done.push_back(c + 6);
    wait_drain(40);
    check("t5_err_sticky", error, 1);

    // 255 threads: 64 blocks, last one carries 3 threads.
    do_reset();
    launch(255, c);
    for (int k = 0; k < 64; k++) q_start.push_back(mk(c + 2 + k, k % NC, k, (k == 63) ? 3 : (1 << L2)));
    q_done.push_back(c + 68);
    wait_drain(120);

    // Reset with three blocks outstanding, then a fresh launch starts on core 0.
    hold = '{20, 20, 20, 20};
    launch(12, c);
    for (int k = 0; k < 3; k++) q_start.push_back(mk(c + 2 + k, k, k, 4));
    repeat (5) @(negedge clk);
    check("t7_busy_pre", busy, 1);
    do_reset();
    hold = '{1, 1, 1, 1};
    launch(4, c);
    q_start.push_back(mk(c + 2, 0, 0, 4));
    q_done.push_back(c + 5);
    wait_drain(40);
    check("t7_error", error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
